// File: rtl/life_generation_engine_if.sv
// Memory-side bus of the generation engine: a row fetch port toward the
// selector's line buffer and a next-state row write port.
interface life_generation_engine_if #(
    parameter int X_SIZE  = 1280,
    parameter int Y_WIDTH = 10
);
    logic [Y_WIDTH-1:0] fetch_addr;
    logic [X_SIZE-1:0]  fetch_data;
    logic [Y_WIDTH-1:0] wr_addr;
    logic [X_SIZE-1:0]  wr_data;
    logic               wr_en;

    // Engine side: issues fetch addresses and next-state writes.
    modport master (
        output fetch_addr,
        input  fetch_data,
        output wr_addr,
        output wr_data,
        output wr_en
    );

    // Selector / memory side.
    modport slave (
        input  fetch_addr,
        output fetch_data,
        input  wr_addr,
        input  wr_data,
        input  wr_en
    );
endinterface

// File: rtl/life_generation_engine.sv
// Conway B3/S23 generation engine. Streams the current generation row by row
// through a 3-row window (prev/cur/nxt), computes a full next-state row in
// parallel and writes it back, then flips the ping-pong buffer select.
// Every output is a register loaded from the next-state decode, so the
// outputs line up exactly with the state they belong to.
module life_generation_engine #(
    parameter int X_SIZE  = 1280,
    parameter int Y_SIZE  = 720,
    parameter int Y_WIDTH = 10,
    parameter int RD_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pause,
    life_generation_engine_if.master mem,
    output logic                    buf_sel,
    output logic                    busy,
    output logic                    gen_done,
    output logic [15:0]             gen_count
);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, CAPTURE, WRITE, FLUSH, WRITE_LAST, SWAP
    } state_t;

    // fetch_ptr needs one extra bit so it can reach Y_SIZE after the last capture.
    localparam int                  PTR_W     = Y_WIDTH + 1;
    localparam logic [PTR_W-1:0]    ROWS      = PTR_W'(Y_SIZE);
    localparam logic [Y_WIDTH-1:0]  PENULT    = Y_WIDTH'(Y_SIZE - 2);
    localparam logic [3:0]          WAIT_LAST = 4'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    state_t              state_r, state_s;
    logic [PTR_W-1:0]    fetch_ptr_r, fetch_ptr_s;
    logic [Y_WIDTH-1:0]  out_row_r, out_row_s;
    logic [3:0]          wait_cnt_r, wait_cnt_s;
    logic [X_SIZE-1:0]   prev_r, prev_s;
    logic [X_SIZE-1:0]   cur_r, cur_s;
    logic [X_SIZE-1:0]   nxt_r, nxt_s;
    logic [X_SIZE-1:0]   next_row_s;
    logic                write_s;

    // B3/S23 over a whole row; padding zeros make out-of-range columns dead.
    function automatic logic [X_SIZE-1:0] life_row(
        input logic [X_SIZE-1:0] p,
        input logic [X_SIZE-1:0] c,
        input logic [X_SIZE-1:0] n
    );
        logic [X_SIZE+1:0] pp;
        logic [X_SIZE+1:0] cp;
        logic [X_SIZE+1:0] np;
        logic [3:0]        cnt;
        logic [X_SIZE-1:0] r;
        pp = {1'b0, p, 1'b0};
        cp = {1'b0, c, 1'b0};
        np = {1'b0, n, 1'b0};
        r  = '0;
        for (int i = 0; i < X_SIZE; i++) begin
            // Padded index i+1 is column i; cp[i+1] is the cell itself.
            cnt = 4'(pp[i]) + 4'(pp[i+1]) + 4'(pp[i+2])
                + 4'(cp[i])               + 4'(cp[i+2])
                + 4'(np[i]) + 4'(np[i+1]) + 4'(np[i+2]);
            r[i] = (cnt == 4'd3) || (c[i] && (cnt == 4'd2));
        end
        return r;
    endfunction

    // Next-state, window shift and row pointer decode.
    always_comb begin
        state_s     = state_r;
        fetch_ptr_s = fetch_ptr_r;
        out_row_s   = out_row_r;
        wait_cnt_s  = wait_cnt_r;
        prev_s      = prev_r;
        cur_s       = cur_r;
        nxt_s       = nxt_r;
        case (state_r)
            IDLE: begin
                if (start && !pause) begin
                    state_s     = FETCH;
                    fetch_ptr_s = '0;
                    out_row_s   = '0;
                    prev_s      = '0;
                    cur_s       = '0;
                    nxt_s       = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                wait_cnt_s = 4'd0;
                if (RD_LAT > 1) begin
                    state_s = WAIT;
                end else begin
                    state_s = CAPTURE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s = CAPTURE;
                end else begin
                    wait_cnt_s = wait_cnt_r + 4'd1;
                end
            end
            CAPTURE: begin
                prev_s      = cur_r;
                cur_s       = nxt_r;
                nxt_s       = mem.fetch_data;
                fetch_ptr_s = fetch_ptr_r + PTR_W'(1);
                // Row 0 alone cannot produce an output row yet.
                if (fetch_ptr_r == '0) begin
                    state_s = FETCH;
                end else begin
                    state_s = WRITE;
                end
            end
            WRITE: begin
                out_row_s = out_row_r + Y_WIDTH'(1);
                if ((fetch_ptr_r == ROWS) && (out_row_r == PENULT)) begin
                    state_s = FLUSH;
                end else begin
                    state_s = FETCH;
                end
            end
            FLUSH: begin
                // Row below the last one is dead.
                prev_s  = cur_r;
                cur_s   = nxt_r;
                nxt_s   = '0;
                state_s = WRITE_LAST;
            end
            WRITE_LAST: begin
                state_s = SWAP;
            end
            SWAP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output row is computed from the window as it will be when the write is visible.
    always_comb begin
        next_row_s = life_row(prev_s, cur_s, nxt_s);
        write_s    = (state_s == WRITE) || (state_s == WRITE_LAST);
    end

    // State, window and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            fetch_ptr_r    <= '0;
            out_row_r      <= '0;
            wait_cnt_r     <= 4'd0;
            prev_r         <= '0;
            cur_r          <= '0;
            nxt_r          <= '0;
            mem.fetch_addr <= '0;
            mem.wr_addr    <= '0;
            mem.wr_data    <= '0;
            mem.wr_en      <= 1'b0;
            buf_sel        <= 1'b0;
            busy           <= 1'b0;
            gen_done       <= 1'b0;
            gen_count      <= 16'd0;
        end else begin
            state_r     <= state_s;
            fetch_ptr_r <= fetch_ptr_s;
            out_row_r   <= out_row_s;
            wait_cnt_r  <= wait_cnt_s;
            prev_r      <= prev_s;
            cur_r       <= cur_s;
            nxt_r       <= nxt_s;
            busy        <= (state_s != IDLE);
            gen_done    <= (state_s == SWAP);
            mem.wr_en   <= write_s;
            if (state_s == FETCH) begin
                mem.fetch_addr <= fetch_ptr_s[Y_WIDTH-1:0];
            end
            if (write_s) begin
                mem.wr_addr <= out_row_s;
                mem.wr_data <= next_row_s;
            end
            if (state_s == SWAP) begin
                buf_sel   <= ~buf_sel;
                gen_count <= gen_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_life_generation_engine.sv
// Directed bench for life_generation_engine on an 8x4 board. Two engines share
// one board image: one with single-cycle reads, one with two-cycle reads.
module tb_life_generation_engine;

    localparam int XS = 8;
    localparam int YS = 4;
    localparam int YW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic start1, start2, pause;
    logic buf_sel1, busy1, gen_done1;
    logic buf_sel2, busy2, gen_done2;
    logic [15:0] gen_count1, gen_count2;

    life_generation_engine_if #(.X_SIZE(XS), .Y_WIDTH(YW)) ifc1();
    life_generation_engine_if #(.X_SIZE(XS), .Y_WIDTH(YW)) ifc2();

    life_generation_engine #(.X_SIZE(XS), .Y_SIZE(YS), .Y_WIDTH(YW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .pause(pause), .mem(ifc1),
        .buf_sel(buf_sel1), .busy(busy1), .gen_done(gen_done1), .gen_count(gen_count1)
    );

    life_generation_engine #(.X_SIZE(XS), .Y_SIZE(YS), .Y_WIDTH(YW), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .pause(pause), .mem(ifc2),
        .buf_sel(buf_sel2), .busy(busy2), .gen_done(gen_done2), .gen_count(gen_count2)
    );

    always #5 clk = ~clk;

    // Board image and read pipelines (1 and 2 cycles).
    logic [7:0] board [YS];
    logic [7:0] rd1_q, rd2_a, rd2_q;
    always @(posedge clk) begin
        rd1_q <= board[ifc1.fetch_addr[1:0]];
        rd2_a <= board[ifc2.fetch_addr[1:0]];
        rd2_q <= rd2_a;
    end
    assign ifc1.fetch_data = rd1_q;
    assign ifc2.fetch_data = rd2_q;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_gen = 0;

    // Monitors: write log, busy cycles, gen_done pulses, compressed fetch sequence.
    logic [3:0] wa1_q[$];
    logic [7:0] wd1_q[$];
    logic [3:0] fa1_q[$];
    int busy1_cyc = 0, done1_cnt = 0;
    logic busy1_prev = 1'b0;
    logic [3:0] fa1_last = 4'd0;
    always @(negedge clk) begin
        if (busy1) begin
            busy1_cyc++;
            if (!busy1_prev || (ifc1.fetch_addr != fa1_last)) fa1_q.push_back(ifc1.fetch_addr);
            fa1_last = ifc1.fetch_addr;
        end
        busy1_prev = busy1;
        if (ifc1.wr_en) begin
            wa1_q.push_back(ifc1.wr_addr);
            wd1_q.push_back(ifc1.wr_data);
        end
        if (gen_done1) done1_cnt++;
    end

    logic [3:0] wa2_q[$];
    logic [7:0] wd2_q[$];
    int busy2_cyc = 0;
    always @(negedge clk) begin
        if (busy2) busy2_cyc++;
        if (ifc2.wr_en) begin
            wa2_q.push_back(ifc2.wr_addr);
            wd2_q.push_back(ifc2.wr_data);
        end
    end

    task automatic wait_done1(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (gen_done1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start1 = 1'b0; start2 = 1'b0; pause = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        vec_cnt++; if (busy1 !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy1); end
        vec_cnt++; if (ifc1.wr_en !== 1'b0) begin err_cnt++; $display("FAIL reset_wr_en got %b want 0", ifc1.wr_en); end
        vec_cnt++; if (buf_sel1 !== 1'b0) begin err_cnt++; $display("FAIL reset_buf_sel got %b want 0", buf_sel1); end
        vec_cnt++; if (gen_count1 !== 16'd0) begin err_cnt++; $display("FAIL reset_gen_count got %0d want 0", gen_count1); end
        vec_cnt++; if ({ifc1.fetch_addr, ifc1.wr_addr, ifc1.wr_data, gen_done1} !== 17'd0) begin
            err_cnt++; $display("FAIL reset_other_outputs got %h want 0", {ifc1.fetch_addr, ifc1.wr_addr, ifc1.wr_data, gen_done1});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++; if (busy1 !== 1'b0) begin err_cnt++; $display("FAIL post_reset_busy got %b want 0", busy1); end
    endtask

    // One generation from a given board; checks the written rows and bookkeeping.
    task automatic test_rule(input string name, input logic [7:0] r0, r1, r2, r3,
                             input logic [7:0] e0, e1, e2, e3);
        logic [7:0] exp_rows [4];
        int bw, bb, bd;
        bit ok;
        exp_rows[0] = e0; exp_rows[1] = e1; exp_rows[2] = e2; exp_rows[3] = e3;
        board[0] = r0; board[1] = r1; board[2] = r2; board[3] = r3;
        bw = wa1_q.size(); bb = busy1_cyc; bd = done1_cnt;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        wait_done1(ok);
        exp_gen++;
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL %s_timeout got no gen_done want gen_done", name); end
        vec_cnt++; if (wa1_q.size() - bw != 4) begin err_cnt++; $display("FAIL %s_write_count got %0d want 4", name, wa1_q.size() - bw); end
        for (int k = 0; k < 4; k++) begin
            if (bw + k < wa1_q.size()) begin
                vec_cnt++;
                if ((wa1_q[bw+k] !== 4'(k)) || (wd1_q[bw+k] !== exp_rows[k])) begin
                    err_cnt++;
                    $display("FAIL %s_row%0d got addr %0d data %h want addr %0d data %h", name, k, wa1_q[bw+k], wd1_q[bw+k], k, exp_rows[k]);
                end
            end
        end
        vec_cnt++; if (busy1_cyc - bb != 14) begin err_cnt++; $display("FAIL %s_busy_cycles got %0d want 14", name, busy1_cyc - bb); end
        vec_cnt++; if (done1_cnt - bd != 1) begin err_cnt++; $display("FAIL %s_gen_done_pulses got %0d want 1", name, done1_cnt - bd); end
        vec_cnt++; if (gen_count1 !== 16'(exp_gen)) begin err_cnt++; $display("FAIL %s_gen_count got %0d want %0d", name, gen_count1, exp_gen); end
        vec_cnt++; if (buf_sel1 !== exp_gen[0]) begin err_cnt++; $display("FAIL %s_buf_sel got %b want %b", name, buf_sel1, exp_gen[0]); end
    endtask

    task automatic test_pause();
        int bw, bb, bf, bd, c;
        bit ok;
        board[0] = 8'h08; board[1] = 8'h08; board[2] = 8'h08; board[3] = 8'h00;
        bw = wa1_q.size(); bb = busy1_cyc; bf = fa1_q.size(); bd = done1_cnt;
        @(negedge clk); pause = 1'b1; start1 = 1'b1;
        repeat (50) @(negedge clk);
        vec_cnt++; if (busy1_cyc != bb) begin err_cnt++; $display("FAIL pause_busy got %0d cycles want 0", busy1_cyc - bb); end
        vec_cnt++; if ((wa1_q.size() != bw) || (fa1_q.size() != bf)) begin
            err_cnt++; $display("FAIL pause_activity got %0d writes %0d fetches want 0 0", wa1_q.size() - bw, fa1_q.size() - bf);
        end
        vec_cnt++; if ((buf_sel1 !== exp_gen[0]) || (gen_count1 !== 16'(exp_gen))) begin
            err_cnt++; $display("FAIL pause_state got buf_sel %b count %0d want %b %0d", buf_sel1, gen_count1, exp_gen[0], exp_gen);
        end
        pause = 1'b0;
        c = 0;
        while (!busy1 && c < 10) begin @(negedge clk); c++; end
        start1 = 1'b0;
        pause = 1'b1;
        wait_done1(ok);
        pause = 1'b0;
        exp_gen++;
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL pause_release_timeout got no gen_done want gen_done"); end
        vec_cnt++; if (done1_cnt - bd != 1) begin err_cnt++; $display("FAIL pause_release_done got %0d want 1", done1_cnt - bd); end
        vec_cnt++; if ((wa1_q.size() - bw != 4) || (wd1_q[wd1_q.size()-3] !== 8'h1C)) begin
            err_cnt++; $display("FAIL pause_release_writes got %0d writes want 4 with row1=1c", wa1_q.size() - bw);
        end
        vec_cnt++; if (gen_count1 !== 16'(exp_gen)) begin err_cnt++; $display("FAIL pause_release_count got %0d want %0d", gen_count1, exp_gen); end
    endtask

    task automatic test_back_to_back();
        int bf, bd, c;
        bit ok;
        board[0] = 8'h08; board[1] = 8'h08; board[2] = 8'h08; board[3] = 8'h00;
        bf = fa1_q.size(); bd = done1_cnt;
        ok = 1'b0;
        @(negedge clk); start1 = 1'b1;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (gen_done1) begin ok = 1'b1; start1 = 1'b0; break; end
        end
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        exp_gen++;
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL b2b_timeout got no gen_done want gen_done"); end
        vec_cnt++; if (fa1_q.size() - bf != 4) begin err_cnt++; $display("FAIL b2b_fetch_count got %0d want 4", fa1_q.size() - bf); end
        for (int k = 0; k < 4; k++) begin
            if (bf + k < fa1_q.size()) begin
                vec_cnt++;
                if (fa1_q[bf+k] !== 4'(k)) begin err_cnt++; $display("FAIL b2b_fetch%0d got %0d want %0d", k, fa1_q[bf+k], k); end
            end
        end
        vec_cnt++; if ((done1_cnt - bd != 1) || (busy1 !== 1'b0)) begin
            err_cnt++; $display("FAIL b2b_single_gen got %0d dones busy %b want 1 0", done1_cnt - bd, busy1);
        end
        vec_cnt++; if (gen_count1 !== 16'(exp_gen)) begin err_cnt++; $display("FAIL b2b_gen_count got %0d want %0d", gen_count1, exp_gen); end
    endtask

    task automatic test_rdlat2();
        logic [7:0] exp_rows [4];
        int bw, bb;
        bit ok;
        exp_rows[0] = 8'h00; exp_rows[1] = 8'h1C; exp_rows[2] = 8'h00; exp_rows[3] = 8'h00;
        board[0] = 8'h08; board[1] = 8'h08; board[2] = 8'h08; board[3] = 8'h00;
        bw = wa2_q.size(); bb = busy2_cyc;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (gen_done2) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL rdlat2_timeout got no gen_done want gen_done"); end
        vec_cnt++; if (wa2_q.size() - bw != 4) begin err_cnt++; $display("FAIL rdlat2_write_count got %0d want 4", wa2_q.size() - bw); end
        for (int k = 0; k < 4; k++) begin
            if (bw + k < wa2_q.size()) begin
                vec_cnt++;
                if ((wa2_q[bw+k] !== 4'(k)) || (wd2_q[bw+k] !== exp_rows[k])) begin
                    err_cnt++;
                    $display("FAIL rdlat2_row%0d got addr %0d data %h want addr %0d data %h", k, wa2_q[bw+k], wd2_q[bw+k], k, exp_rows[k]);
                end
            end
        end
        vec_cnt++; if (busy2_cyc - bb != 18) begin err_cnt++; $display("FAIL rdlat2_busy_cycles got %0d want 18", busy2_cyc - bb); end
        vec_cnt++; if ((gen_count2 !== 16'd1) || (buf_sel2 !== 1'b1)) begin
            err_cnt++; $display("FAIL rdlat2_swap got count %0d buf_sel %b want 1 1", gen_count2, buf_sel2);
        end
    endtask

    task automatic test_abort();
        int k, bw, bf;
        bit ok;
        board[0] = 8'h08; board[1] = 8'h08; board[2] = 8'h08; board[3] = 8'h00;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        k = 0;
        for (int c = 0; c < 50; c++) begin
            if (busy1) k++;
            if (k == 6) break;
            @(negedge clk);
        end
        vec_cnt++; if (k != 6) begin err_cnt++; $display("FAIL abort_reach_cycle6 got %0d busy cycles want 6", k); end
        #2 rst_n = 1'b0;
        #1;
        exp_gen = 0;
        vec_cnt++; if ((ifc1.wr_en !== 1'b0) || (busy1 !== 1'b0)) begin
            err_cnt++; $display("FAIL abort_wr_en_busy got %b %b want 0 0", ifc1.wr_en, busy1);
        end
        vec_cnt++; if ((buf_sel1 !== 1'b0) || (gen_count1 !== 16'd0)) begin
            err_cnt++; $display("FAIL abort_buf_sel_count got %b %0d want 0 0", buf_sel1, gen_count1);
        end
        vec_cnt++; if ((gen_count2 !== 16'd0) || (buf_sel2 !== 1'b0)) begin
            err_cnt++; $display("FAIL abort_dut2 got count %0d buf_sel %b want 0 0", gen_count2, buf_sel2);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        bw = wa1_q.size(); bf = fa1_q.size();
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        wait_done1(ok);
        exp_gen++;
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL abort_rerun_timeout got no gen_done want gen_done"); end
        vec_cnt++; if ((fa1_q.size() - bf != 4) || (fa1_q[bf] !== 4'd0)) begin
            err_cnt++; $display("FAIL abort_rerun_fetch got %0d fetches want 4 from row 0", fa1_q.size() - bf);
        end
        vec_cnt++; if ((wa1_q.size() - bw != 4) || (wa1_q[bw] !== 4'd0) || (wd1_q[bw+1] !== 8'h1C)) begin
            err_cnt++; $display("FAIL abort_rerun_writes got %0d writes want 4 from row 0 with row1=1c", wa1_q.size() - bw);
        end
        vec_cnt++; if ((gen_count1 !== 16'd1) || (buf_sel1 !== 1'b1)) begin
            err_cnt++; $display("FAIL abort_rerun_state got count %0d buf_sel %b want 1 1", gen_count1, buf_sel1);
        end
    endtask

    initial begin
        board[0] = 8'h00; board[1] = 8'h00; board[2] = 8'h00; board[3] = 8'h00;
        test_reset();
        test_rule("blinker", 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00);
        test_rule("row_edge", 8'h07, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00);
        test_rule("col_edge", 8'h00, 8'h83, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        test_pause();
        test_back_to_back();
        test_rdlat2();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
